// File: rtl/vme_resp_pkg.sv
// Shared types and constants for the VME A32/D32 responder.
package vme_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT     = 3'd3,
        S_DTACK    = 3'd4,
        S_BERR     = 3'd5,
        S_RELEASE  = 3'd6,
        S_WAIT_REL = 3'd7
    } t_resp_state;

    localparam logic [5:0] c_AM_A32_USER_DATA = 6'h09;
    localparam logic [5:0] c_AM_A32_SUP_DATA  = 6'h0D;

    function automatic logic f_am_supported(input logic [5:0] am);
        return (am == c_AM_A32_USER_DATA) || (am == c_AM_A32_SUP_DATA);
    endfunction

endpackage

// File: rtl/vme_strobe_sync.sv
// Brings AS_n/DS_n into the clk domain. as_q: AS asserted; ds_q: D32 strobe
// (AS and both DS low for two consecutive clocks); ds_rel: both DS high.
module vme_strobe_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       as_n,
    input  logic [1:0] ds_n,
    output logic       as_q,
    output logic       ds_q,
    output logic       ds_rel
);

    logic       as_meta, as_sync;
    logic [1:0] ds_meta, ds_sync;
    logic       strobe_now, strobe_prev;

    assign strobe_now = !as_sync && (ds_sync == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_meta     <= 1'b1;
            as_sync     <= 1'b1;
            ds_meta     <= 2'b11;
            ds_sync     <= 2'b11;
            strobe_prev <= 1'b0;
        end else begin
            as_meta     <= as_n;
            as_sync     <= as_meta;
            ds_meta     <= ds_n;
            ds_sync     <= ds_meta;
            strobe_prev <= strobe_now;
        end
    end

    assign as_q   = !as_sync;
    assign ds_q   = strobe_now && strobe_prev;
    assign ds_rel = (ds_sync == 2'b11);

endmodule

// File: rtl/vme_a32d32_responder.sv
// VME64x single-cycle A32/D32 slave: one decoded window, each VME cycle becomes
// one pipelined Wishbone access answered with DTACK, or BERR on error/timeout.
module vme_a32d32_responder
    import vme_resp_pkg::*;
#(
    parameter logic [31:0] g_BASE_ADDR   = 32'h80000000,
    parameter int          g_WINDOW_BITS = 20,
    parameter int          g_WB_TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        vme_as_n_i,
    input  logic [1:0]  vme_ds_n_i,
    input  logic        vme_write_n_i,
    input  logic [5:0]  vme_am_i,
    input  logic [31:1] vme_addr_i,
    input  logic        vme_lword_n_i,
    input  logic [31:0] vme_data_i,
    output logic [31:0] vme_data_o,
    output logic        vme_data_oe_o,
    output logic        vme_dtack_n_o,
    output logic        vme_dtack_oe_o,
    output logic        vme_berr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam logic [31:0] c_WIN_MASK = (32'h1 << g_WINDOW_BITS) - 32'h1;
    localparam logic [7:0]  c_TMO      = 8'(g_WB_TIMEOUT);

    t_resp_state state;
    logic        as_q, ds_q, ds_rel;
    logic [31:0] addr_r, data_r;
    logic [5:0]  am_r;
    logic        write_n_r, lword_n_r;
    logic [7:0]  tmo_cnt;
    logic        aborted;
    logic        hit, legal, abort_now, wb_done;

    vme_strobe_sync u_sync (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .as_n   (vme_as_n_i),
        .ds_n   (vme_ds_n_i),
        .as_q   (as_q),
        .ds_q   (ds_q),
        .ds_rel (ds_rel)
    );

    // Bus lines are stable once the strobe has qualified, so a plain capture is safe.
    always_ff @(posedge clk_i) begin
        if (state == S_IDLE && ds_q) begin
            addr_r    <= {vme_addr_i, 1'b0};
            am_r      <= vme_am_i;
            write_n_r <= vme_write_n_i;
            lword_n_r <= vme_lword_n_i;
            data_r    <= vme_data_i;
        end
    end

    assign hit       = f_am_supported(am_r) && (((addr_r ^ g_BASE_ADDR) & ~c_WIN_MASK) == 32'h0);
    assign legal     = !lword_n_r && !addr_r[1];
    assign abort_now = aborted || !as_q;
    assign wb_done   = wb_ack_i || wb_err_i || (tmo_cnt == c_TMO);
    assign wb_sel_o  = 4'hF;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= S_IDLE;
            vme_data_o     <= 32'h0;
            vme_data_oe_o  <= 1'b0;
            vme_dtack_n_o  <= 1'b1;
            vme_dtack_oe_o <= 1'b0;
            vme_berr_o     <= 1'b0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_adr_o       <= 32'h0;
            wb_dat_o       <= 32'h0;
            tmo_cnt        <= 8'h0;
            aborted        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (ds_q) state <= S_DECODE;
                S_DECODE: begin
                    aborted <= 1'b0;
                    if (hit && legal) begin
                        state    <= S_REQ;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= !write_n_r;
                        wb_adr_o <= addr_r & c_WIN_MASK;
                        wb_dat_o <= data_r;
                    end else if (hit) begin
                        state      <= S_BERR;
                        vme_berr_o <= 1'b1;
                    end else begin
                        state <= S_WAIT_REL;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= 8'h0;
                    if (!as_q) aborted <= 1'b1;
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!as_q) aborted <= 1'b1;
                    if (wb_done) begin
                        wb_cyc_o <= 1'b0;
                        // An aborted master gets no answer; the slave's result is dropped.
                        if (abort_now) begin
                            state <= S_IDLE;
                        end else if (wb_ack_i) begin
                            state <= S_DTACK;
                            if (write_n_r) begin
                                vme_data_o    <= wb_dat_i;
                                vme_data_oe_o <= 1'b1;
                            end else begin
                                vme_dtack_n_o  <= 1'b0;
                                vme_dtack_oe_o <= 1'b1;
                            end
                        end else begin
                            state      <= S_BERR;
                            vme_berr_o <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DTACK: begin
                    if (vme_dtack_n_o) begin
                        vme_dtack_n_o  <= 1'b0;
                        vme_dtack_oe_o <= 1'b1;
                    end else if (ds_rel) begin
                        vme_dtack_n_o <= 1'b1;
                        state         <= S_RELEASE;
                    end
                end
                S_BERR: if (ds_rel) state <= S_RELEASE;
                S_RELEASE: begin
                    vme_data_oe_o  <= 1'b0;
                    vme_dtack_oe_o <= 1'b0;
                    vme_berr_o     <= 1'b0;
                    state          <= S_WAIT_REL;
                end
                S_WAIT_REL: if (!as_q) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vme_a32d32_responder.sv
// Directed plus randomized bench: the bench plays VME master and Wishbone slave.
module tb_vme_a32d32_responder;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        vme_as_n_i;
    logic [1:0]  vme_ds_n_i;
    logic        vme_write_n_i;
    logic [5:0]  vme_am_i;
    logic [31:1] vme_addr_i;
    logic        vme_lword_n_i;
    logic [31:0] vme_data_i;
    logic [31:0] vme_data_o;
    logic        vme_data_oe_o, vme_dtack_n_o, vme_dtack_oe_o, vme_berr_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

    int errors = 0;
    int checks = 0;

    // slave configuration (written by the main sequence only)
    int cfg_mode  = 0;   // 0 ack, 1 err, 2 never respond
    int cfg_stall = 0;
    int cfg_delay = 1;

    // slave record (written by the slave process only)
    int          wb_count = 0;
    logic [31:0] last_adr = '0, last_dat = '0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = '0;

    // monitor record (written by the monitor process only)
    int   dtack_events = 0, berr_events = 0, cyc_len = 0, last_cyc_len = 0;
    logic oe_lead = 1'b0, dtack_oe_at_fall = 1'b0;

    always #5 clk = ~clk;

    vme_a32d32_responder dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .vme_as_n_i(vme_as_n_i), .vme_ds_n_i(vme_ds_n_i), .vme_write_n_i(vme_write_n_i),
        .vme_am_i(vme_am_i), .vme_addr_i(vme_addr_i), .vme_lword_n_i(vme_lword_n_i),
        .vme_data_i(vme_data_i), .vme_data_o(vme_data_o), .vme_data_oe_o(vme_data_oe_o),
        .vme_dtack_n_o(vme_dtack_n_o), .vme_dtack_oe_o(vme_dtack_oe_o), .vme_berr_o(vme_berr_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
    );

    // Wishbone pipelined slave model
    initial begin
        int  stall_left, pend_dly, pend_mode;
        bit  pend, in_req;
        stall_left = 0; pend_dly = 0; pend_mode = 0; pend = 0; in_req = 0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (!wb_cyc_o) pend = 0;
            if (pend) begin
                if (pend_dly <= 1) begin
                    pend = 0;
                    if (pend_mode == 0) wb_ack_i = 1'b1;
                    else wb_err_i = 1'b1;
                end else begin
                    pend_dly--;
                end
            end
            if (wb_cyc_o && wb_stb_o) begin
                if (!in_req) begin
                    in_req = 1;
                    stall_left = cfg_stall;
                end
                if (stall_left > 0) begin
                    wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    wb_stall_i = 1'b0;
                    in_req = 0;
                    wb_count++;
                    last_adr = wb_adr_o;
                    last_dat = wb_dat_o;
                    last_we  = wb_we_o;
                    last_sel = wb_sel_o;
                    if (cfg_mode != 2) begin
                        pend = 1;
                        pend_dly = cfg_delay;
                        pend_mode = cfg_mode;
                    end
                end
            end else begin
                in_req = 0;
                wb_stall_i = 1'b0;
            end
        end
    end

    // VME-side event monitor
    initial begin
        logic prev_dtack_n, prev_oe, prev_berr, prev_cyc;
        prev_dtack_n = 1'b1; prev_oe = 1'b0; prev_berr = 1'b0; prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (!vme_dtack_n_o && prev_dtack_n) begin
                dtack_events++;
                oe_lead = prev_oe;
                dtack_oe_at_fall = vme_dtack_oe_o;
            end
            if (vme_berr_o && !prev_berr) berr_events++;
            if (wb_cyc_o) cyc_len++;
            else if (prev_cyc) begin
                last_cyc_len = cyc_len;
                cyc_len = 0;
            end
            prev_dtack_n = vme_dtack_n_o;
            prev_oe      = vme_data_oe_o;
            prev_berr    = vme_berr_o;
            prev_cyc     = wb_cyc_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the address map rules: 0 = not selected, 1 = DTACK, 2 = BERR.
    function automatic int model_result(input logic [31:0] addr, input logic [5:0] am,
                                        input logic lw, input int mode, output logic wb_exp);
        logic sel_hit;
        sel_hit = (am == 6'h09 || am == 6'h0D) && (addr[31:20] == 12'h800);
        wb_exp = 1'b0;
        if (!sel_hit) return 0;
        if (lw || addr[1]) return 2;
        wb_exp = 1'b1;
        return (mode == 0) ? 1 : 2;
    endfunction

    task automatic vme_cycle(input logic [31:0] addr, input logic [5:0] am, input logic lw,
                             input logic wr_n, input logic [31:0] wd, input logic [1:0] ds,
                             output int res, output logic [31:0] rd);
        bit released;
        vme_addr_i    = addr[31:1];
        vme_am_i      = am;
        vme_lword_n_i = lw;
        vme_write_n_i = wr_n;
        vme_data_i    = wd;
        rd  = 32'h0;
        res = 0;
        @(negedge clk);
        vme_as_n_i = 1'b0;
        @(negedge clk);
        vme_ds_n_i = ds;
        for (int i = 0; i < 320 && res == 0; i++) begin
            @(negedge clk);
            if (!vme_dtack_n_o) begin
                res = 1;
                rd  = vme_data_o;
            end else if (vme_berr_o) begin
                res = 2;
            end
        end
        vme_ds_n_i = 2'b11;
        released = 0;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge clk);
            if (vme_dtack_n_o && !vme_berr_o) released = 1;
        end
        check("release_after_ds", 32'(released), 32'd1);
        repeat (2) @(negedge clk);
        vme_as_n_i = 1'b1;
        repeat (6) @(negedge clk);
        check("drivers_off", {30'h0, vme_dtack_oe_o, vme_data_oe_o}, 32'h0);
    endtask

    initial begin
        int          res, n0, d0, b0;
        logic [31:0] rd;
        logic        wb_exp;
        bit          seen;

        rst_n_i = 1'b0;
        vme_as_n_i = 1'b1; vme_ds_n_i = 2'b11; vme_write_n_i = 1'b1;
        vme_am_i = 6'h0; vme_addr_i = '0; vme_lword_n_i = 1'b1; vme_data_i = '0;
        wb_dat_i = '0;
        repeat (3) @(negedge clk);
        check("rst_dtack_n",  32'(vme_dtack_n_o), 32'd1);
        check("rst_dtack_oe", 32'(vme_dtack_oe_o), 32'd0);
        check("rst_berr",     32'(vme_berr_o), 32'd0);
        check("rst_data_oe",  32'(vme_data_oe_o), 32'd0);
        check("rst_data_o",   vme_data_o, 32'h0);
        check("rst_cyc_stb_we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        check("rst_adr",      wb_adr_o, 32'h0);
        check("rst_dat_o",    wb_dat_o, 32'h0);
        check("rst_sel",      32'(wb_sel_o), 32'hF);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk);

        // basic write
        cfg_mode = 0; cfg_stall = 0; cfg_delay = 1;
        n0 = wb_count;
        vme_cycle(32'h80000010, 6'h09, 1'b0, 1'b0, 32'h11223344, 2'b00, res, rd);
        check("wr_result", 32'(res), 32'd1);
        check("wr_wb_count", 32'(wb_count - n0), 32'd1);
        check("wr_adr", last_adr, 32'h10);
        check("wr_dat", last_dat, 32'h11223344);
        check("wr_we", 32'(last_we), 32'd1);
        check("wr_sel", 32'(last_sel), 32'hF);
        check("wr_dtack_oe", 32'(dtack_oe_at_fall), 32'd1);

        // basic read
        wb_dat_i = 32'hDDEEFF00;
        vme_cycle(32'h80000010, 6'h0D, 1'b0, 1'b1, 32'h0, 2'b00, res, rd);
        check("rd_result", 32'(res), 32'd1);
        check("rd_data", rd, 32'hDDEEFF00);
        check("rd_we", 32'(last_we), 32'd0);
        check("rd_oe_before_dtack", 32'(oe_lead), 32'd1);

        // not selected: wrong base, wrong AM, single data strobe
        n0 = wb_count; d0 = dtack_events; b0 = berr_events;
        vme_cycle(32'h90000000, 6'h09, 1'b0, 1'b0, 32'h1, 2'b00, res, rd);
        check("nosel_base", 32'(res), 32'd0);
        vme_cycle(32'h80000010, 6'h39, 1'b0, 1'b0, 32'h2, 2'b00, res, rd);
        check("nosel_am", 32'(res), 32'd0);
        vme_cycle(32'h80000010, 6'h09, 1'b0, 1'b0, 32'h3, 2'b10, res, rd);
        check("single_ds", 32'(res), 32'd0);
        check("nosel_no_wb", 32'(wb_count - n0), 32'd0);
        check("nosel_no_dtack_berr", 32'((dtack_events - d0) + (berr_events - b0)), 32'd0);

        // Wishbone timeout
        cfg_mode = 2;
        n0 = wb_count;
        vme_cycle(32'h80000020, 6'h09, 1'b0, 1'b0, 32'h4, 2'b00, res, rd);
        check("tmo_result", 32'(res), 32'd2);
        check("tmo_wb_count", 32'(wb_count - n0), 32'd1);
        check("tmo_cyc_len", 32'(last_cyc_len >= 250 && last_cyc_len <= 262), 32'd1);

        // Wishbone error
        cfg_mode = 1;
        vme_cycle(32'h80000024, 6'h0D, 1'b0, 1'b1, 32'h0, 2'b00, res, rd);
        check("err_result", 32'(res), 32'd2);
        cfg_mode = 0;

        // D16 access
        n0 = wb_count;
        vme_cycle(32'h80000002, 6'h09, 1'b1, 1'b0, 32'h5, 2'b00, res, rd);
        check("d16_result", 32'(res), 32'd2);
        check("d16_no_wb", 32'(wb_count - n0), 32'd0);

        // abort during stall
        cfg_stall = 6;
        n0 = wb_count; d0 = dtack_events; b0 = berr_events;
        vme_addr_i = 31'(32'h80000030 >> 1); vme_am_i = 6'h09; vme_lword_n_i = 1'b0;
        vme_write_n_i = 1'b0; vme_data_i = 32'h5A5A5A5A;
        @(negedge clk); vme_as_n_i = 1'b0;
        @(negedge clk); vme_ds_n_i = 2'b00;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wb_stb_o) seen = 1;
        end
        check("abort_stb_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vme_as_n_i = 1'b1; vme_ds_n_i = 2'b11;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (!wb_cyc_o) seen = 1;
        end
        check("abort_cyc_ends", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        check("abort_wb_count", 32'(wb_count - n0), 32'd1);
        check("abort_no_dtack_berr", 32'((dtack_events - d0) + (berr_events - b0)), 32'd0);
        cfg_stall = 0;
        vme_cycle(32'h80000040, 6'h09, 1'b0, 1'b0, 32'hCAFEF00D, 2'b00, res, rd);
        check("post_abort_result", 32'(res), 32'd1);
        check("post_abort_dat", last_dat, 32'hCAFEF00D);

        // reset in the middle of a Wishbone cycle
        cfg_mode = 2;
        vme_addr_i = 31'(32'h80000050 >> 1); vme_write_n_i = 1'b0;
        @(negedge clk); vme_as_n_i = 1'b0;
        @(negedge clk); vme_ds_n_i = 2'b00;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wb_cyc_o) seen = 1;
        end
        check("midrst_cyc_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        check("midrst_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("midrst_vme", {29'h0, vme_dtack_n_o, vme_dtack_oe_o, vme_berr_o}, 32'h4);
        check("midrst_adr", wb_adr_o, 32'h0);
        vme_as_n_i = 1'b1; vme_ds_n_i = 2'b11;
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk);
        cfg_mode = 0;

        // randomized transactions against the reference model
        for (int t = 0; t < 30; t++) begin
            logic [31:0] addr, wd;
            logic [5:0]  am;
            logic        lw, wr_n;
            int          sel, amsel, exp_res;
            sel   = $urandom_range(0, 9);
            addr  = {12'h800, 20'($urandom)} & ~32'h3;
            if (sel == 0) addr = $urandom & ~32'h1;
            if (sel == 1) addr = addr | 32'h2;
            amsel = $urandom_range(0, 7);
            am    = (amsel < 3) ? 6'h09 : (amsel < 6) ? 6'h0D : (amsel == 6) ? 6'h39 : 6'($urandom);
            lw    = ($urandom_range(0, 7) == 0);
            wr_n  = 1'($urandom);
            wd    = $urandom;
            cfg_mode  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            cfg_stall = $urandom_range(0, 3);
            cfg_delay = $urandom_range(1, 3);
            wb_dat_i  = $urandom;
            exp_res   = model_result(addr, am, lw, cfg_mode, wb_exp);
            n0 = wb_count;
            vme_cycle(addr, am, lw, wr_n, wd, 2'b00, res, rd);
            check("rand_result", 32'(res), 32'(exp_res));
            check("rand_wb_count", 32'(wb_count - n0), 32'(wb_exp));
            if (wb_exp) begin
                check("rand_adr", last_adr, addr & 32'h000FFFFF);
                check("rand_we", 32'(last_we), 32'(!wr_n));
                if (!wr_n) check("rand_wdat", last_dat, wd);
                else if (exp_res == 1) check("rand_rdat", rd, wb_dat_i);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
